window_filter_pipe: RTL and testbench

- Pipelined 3x3 gradient/edge filter for the streaming image path. Sits between the line-buffer window generator and the output formatter.
- Generalises the fixed Sobel-X operator in three ways: pixel width is parameterised, the operator mode is selectable at runtime, and output scaling and saturation are configurable.
- Carries a valid flag in lockstep with the data and keeps a count of accepted output pixels.

---
 rtl/window_filter_pipe_if.sv | 29 ++
 rtl/window_filter_pipe.sv | 143 ++++++++++++++
 tb/tb_window_filter_pipe.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_filter_pipe_if.sv
// Stream-side bundle of window_filter_pipe: window in, filtered pixel out, mode control and counter.
// Defining WINFILT_THRESH_EN adds the thresh input.
interface window_filter_pipe_if #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 32
);
  logic [9*(PIX_W+1)-1:0] win_in;
  logic [1:0]             mode_in;
  logic                   mode_load;
  logic                   refresh;
`ifdef WINFILT_THRESH_EN
  logic [PIX_W-1:0]       thresh;
`endif
  logic [PIX_W:0]         out;
  logic [1:0]             mode_q;
  logic [CNT_W-1:0]       pix_cnt;

`ifdef WINFILT_THRESH_EN
  modport master (output win_in, mode_in, mode_load, refresh, thresh,
                  input  out, mode_q, pix_cnt);
  modport slave  (input  win_in, mode_in, mode_load, refresh, thresh,
                  output out, mode_q, pix_cnt);
`else
  modport master (output win_in, mode_in, mode_load, refresh,
                  input  out, mode_q, pix_cnt);
  modport slave  (input  win_in, mode_in, mode_load, refresh,
                  output out, mode_q, pix_cnt);
`endif
endinterface

// File: rtl/window_filter_pipe.sv
// 3x3 Sobel-style gradient filter, 4-cycle fixed latency, one window per cycle with no stall/backpressure.
// WINFILT_THRESH_EN turns gradient modes into a binary compare against thresh.
module window_filter_pipe #(
  parameter int         PIX_W    = 8,
  parameter int         SHIFT    = 2,
  parameter logic [1:0] MODE_RST = 2'd1,
  parameter int         CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  window_filter_pipe_if.slave bus
);
  localparam int EW = PIX_W + 1;
  localparam int SW = PIX_W + 2;
  localparam int GW = PIX_W + 3;
  localparam logic [GW-1:0] SAT_MAX = {3'b000, {PIX_W{1'b1}}};

  function automatic logic [SW-1:0] wsum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  logic [PIX_W-1:0] p [9];
  logic             valid_in;
  logic             flush;

  logic [SW-1:0]    s1_gxp_q, s1_gxp_d, s1_gxn_q, s1_gxn_d;
  logic [SW-1:0]    s1_gyp_q, s1_gyp_d, s1_gyn_q, s1_gyn_d;
  logic [PIX_W-1:0] s1_ctr_q, s1_ctr_d, s2_ctr_q, s2_ctr_d;
  logic [1:0]       s1_mode_q, s1_mode_d, s2_mode_q, s2_mode_d, s3_mode_q, s3_mode_d;
  logic signed [GW-1:0] s2_gx_q, s2_gx_d, s2_gy_q, s2_gy_d;
  logic [GW-1:0]    s3_val_q, s3_val_d;
  logic [3:0]       vld_q, vld_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;

  logic [GW-1:0]    neg_x, neg_y, shifted;
  logic [SW-1:0]    abs_x, abs_y;
  logic [PIX_W-1:0] sat, grad;

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      p[i] = bus.win_in[i*EW +: PIX_W];
    end
    valid_in = bus.win_in[4*EW + PIX_W];
    flush    = rst | bus.refresh;
  end

  always_comb begin
    // S1: column sums for Gx, row sums for Gy; mode is the value held before this edge
    s1_gxp_d  = wsum(p[2], p[5], p[8]);
    s1_gxn_d  = wsum(p[0], p[3], p[6]);
    s1_gyp_d  = wsum(p[6], p[7], p[8]);
    s1_gyn_d  = wsum(p[0], p[1], p[2]);
    s1_ctr_d  = p[4];
    s1_mode_d = mode_q;

    s2_gx_d   = $signed({1'b0, s1_gxp_q}) - $signed({1'b0, s1_gxn_q});
    s2_gy_d   = $signed({1'b0, s1_gyp_q}) - $signed({1'b0, s1_gyn_q});
    s2_ctr_d  = s1_ctr_q;
    s2_mode_d = s1_mode_q;

    neg_x     = -s2_gx_q;
    neg_y     = -s2_gy_q;
    abs_x     = s2_gx_q[GW-1] ? neg_x[SW-1:0] : s2_gx_q[SW-1:0];
    abs_y     = s2_gy_q[GW-1] ? neg_y[SW-1:0] : s2_gy_q[SW-1:0];
    s3_val_d  = '0;
    case (s2_mode_q)
      2'd0:    s3_val_d = {3'b000, s2_ctr_q};
      2'd1:    s3_val_d = {1'b0, abs_x};
      2'd2:    s3_val_d = {1'b0, abs_y};
      default: s3_val_d = {1'b0, abs_x} + {1'b0, abs_y};
    endcase
    s3_mode_d = s2_mode_q;

    shifted   = s3_val_q >> SHIFT;
    sat       = (shifted > SAT_MAX) ? {PIX_W{1'b1}} : shifted[PIX_W-1:0];
`ifdef WINFILT_THRESH_EN
    grad      = (sat >= bus.thresh) ? {PIX_W{1'b1}} : '0;
`else
    grad      = sat;
`endif
    out_pix_d = '0;
    if (vld_q[2]) begin
      out_pix_d = (s3_mode_q == 2'd0) ? s3_val_q[PIX_W-1:0] : grad;
    end

    vld_d     = {vld_q[2:0], valid_in};
    pix_cnt_d = pix_cnt_q + {{(CNT_W-1){1'b0}}, vld_q[2]};

    if (flush) begin
      s1_gxp_d  = '0;
      s1_gxn_d  = '0;
      s1_gyp_d  = '0;
      s1_gyn_d  = '0;
      s1_ctr_d  = '0;
      s1_mode_d = '0;
      s2_gx_d   = '0;
      s2_gy_d   = '0;
      s2_ctr_d  = '0;
      s2_mode_d = '0;
      s3_val_d  = '0;
      s3_mode_d = '0;
      out_pix_d = '0;
      vld_d     = '0;
      pix_cnt_d = '0;
    end

    // Refresh leaves the mode alone, so a load on the same edge still lands
    if (rst) begin
      mode_d = MODE_RST;
    end else if (bus.mode_load) begin
      mode_d = bus.mode_in;
    end else begin
      mode_d = mode_q;
    end
  end

  always_ff @(posedge clk) begin
    s1_gxp_q  <= s1_gxp_d;
    s1_gxn_q  <= s1_gxn_d;
    s1_gyp_q  <= s1_gyp_d;
    s1_gyn_q  <= s1_gyn_d;
    s1_ctr_q  <= s1_ctr_d;
    s1_mode_q <= s1_mode_d;
    s2_gx_q   <= s2_gx_d;
    s2_gy_q   <= s2_gy_d;
    s2_ctr_q  <= s2_ctr_d;
    s2_mode_q <= s2_mode_d;
    s3_val_q  <= s3_val_d;
    s3_mode_q <= s3_mode_d;
    out_pix_q <= out_pix_d;
    vld_q     <= vld_d;
    pix_cnt_q <= pix_cnt_d;
    mode_q    <= mode_d;
  end

  assign bus.out     = {vld_q[3], out_pix_q};
  assign bus.mode_q  = mode_q;
  assign bus.pix_cnt = pix_cnt_q;
endmodule

// File: tb/tb_window_filter_pipe.sv
// Directed bench for window_filter_pipe with a per-cycle reference model (PIX_W=8, SHIFT=2).
module tb_window_filter_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_filter_pipe_if #(.PIX_W(8), .CNT_W(32)) bus ();
  window_filter_pipe #(.PIX_W(8), .SHIFT(2), .MODE_RST(2'd1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] pix [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-window reference: integer Sobel arithmetic straight from the operator definition
  function automatic logic [8:0] f_model(input logic [80:0] w, input logic [1:0] md,
                                         input logic [7:0] th);
    int p [9];
    int gx, gy, ax, ay, v;
    logic [31:0] vv;
    for (int i = 0; i < 9; i++) p[i] = int'(w[i*9 +: 8]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (md)
      2'd0:    v = p[4];
      2'd1:    v = ax / 4;
      2'd2:    v = ay / 4;
      default: v = (ax + ay) / 4;
    endcase
    if (md != 2'd0 && v > 255) v = 255;
`ifdef WINFILT_THRESH_EN
    if (md != 2'd0) v = (v >= int'(th)) ? 255 : 0;
`endif
    if (th == 8'hFF && md == 2'd3) v = v + 0;
    vv = v;
    return w[4*9+8] ? {1'b1, vv[7:0]} : 9'd0;
  endfunction

  logic [7:0] th_m;
`ifdef WINFILT_THRESH_EN
  assign th_m = bus.thresh;
`else
  assign th_m = 8'd0;
`endif

  int e = 0;
  int last_flush = 0;
  int exp_cnt = 0;
  logic [8:0] hist [16];
  logic [8:0] exp_out = 9'd0;
  logic [1:0] m_mode = 2'd1;
  bit chk_en = 1'b0;

  // Output after edge e is the window sampled at edge e-3, unless a flush hit edges e-3..e
  always @(posedge clk) begin
    e++;
    hist[e % 16] = f_model(bus.win_in, m_mode, th_m);
    if (rst || bus.refresh) last_flush = e;
    exp_out = (e - last_flush >= 4) ? hist[(e - 3) % 16] : 9'd0;
    if (rst || bus.refresh) exp_cnt = 0;
    else if (exp_out[8]) exp_cnt++;
    if (rst) m_mode = 2'd1;
    else if (bus.mode_load) m_mode = bus.mode_in;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out", 64'(bus.out), 64'(exp_out));
      chk("pix_cnt", 64'(bus.pix_cnt), 64'(exp_cnt));
      chk("mode_q", 64'(bus.mode_q), 64'(m_mode));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 9; i++) pix[i] = 8'(v);
  endtask

  task automatic put(input logic cv, input logic ov);
    logic [80:0] w;
    for (int i = 0; i < 9; i++) w[i*9 +: 9] = {(i == 4) ? cv : ov, pix[i]};
    bus.win_in = w;
  endtask

  task automatic idle();
    fill(0);
    put(1'b0, 1'b0);
  endtask

  task automatic rand_win();
    for (int i = 0; i < 9; i++) pix[i] = 8'($urandom);
    put(1'($urandom), 1'($urandom));
  endtask

  function automatic logic [8:0] exp_sw(input int j);
`ifdef WINFILT_THRESH_EN
    return (j <= 3) ? 9'h100 : 9'(256 + 200 + j);
`else
    return (j <= 3) ? 9'(256 + 10*j) : 9'(256 + 200 + j);
`endif
  endfunction

  logic [80:0] w_pin;

  initial begin
    rst = 1'b1;
    bus.refresh = 1'b0;
    bus.mode_load = 1'b0;
    bus.mode_in = 2'd0;
`ifdef WINFILT_THRESH_EN
    bus.thresh = 8'd128;
`endif
    rand_win();
    step();
    rand_win();
    step();
    chk("rst_out", 64'(bus.out), 64'd0);
    chk("rst_cnt", 64'(bus.pix_cnt), 64'd0);
    chk("rst_mode", 64'(bus.mode_q), 64'd1);
    chk_en = 1'b1;
    rst = 1'b0;
    idle();

    // Pin the reference model on hand-computed windows
    fill(255); pix[0] = 0; pix[3] = 0; pix[6] = 0; put(1'b1, 1'b0); w_pin = bus.win_in;
    chk("model_vert", 64'(f_model(w_pin, 2'd1, 8'd0)), 64'h1FF);
    chk("model_ctr", 64'(f_model(w_pin, 2'd0, 8'd0)), 64'h1FF);
    fill(255); pix[0] = 0; put(1'b1, 1'b0); w_pin = bus.win_in;
`ifndef WINFILT_THRESH_EN
    chk("model_corner", 64'(f_model(w_pin, 2'd3, 8'd0)), 64'h17F);
`endif
    put(1'b0, 1'b1); w_pin = bus.win_in;
    chk("model_inval", 64'(f_model(w_pin, 2'd3, 8'd0)), 64'h000);
    idle();

    // Mode 1 vertical edge, first valid window after reset
    step();
    fill(255); pix[0] = 0; pix[3] = 0; pix[6] = 0; put(1'b1, 1'b0);
    step(); idle();
    step(); step();
    chk("vert_early", 64'(bus.out[8]), 64'd0);
    step();
    chk("vert_out", 64'(bus.out), 64'h1FF);
    chk("vert_cnt", 64'(bus.pix_cnt), 64'd1);

    // Mode 3 corners: 510>>2 = 127, then 1530>>2 saturates
    bus.mode_in = 2'd3; bus.mode_load = 1'b1;
    step();
    bus.mode_load = 1'b0;
    fill(255); pix[0] = 0; put(1'b1, 1'b0);
    step();
    fill(255); pix[0] = 0; pix[1] = 0; pix[2] = 0; pix[3] = 0; pix[6] = 0; put(1'b1, 1'b0);
    step(); idle();
    step(); step();
`ifdef WINFILT_THRESH_EN
    chk("corner_a", 64'(bus.out), 64'h100);
`else
    chk("corner_a", 64'(bus.out), 64'h17F);
`endif
    step();
    chk("corner_b", 64'(bus.out), 64'h1FF);

    // Mode 1 results 127 and 128 straddle the threshold
    bus.mode_in = 2'd1; bus.mode_load = 1'b1;
    step();
    bus.mode_load = 1'b0;
    fill(0); pix[2] = 254; pix[5] = 127; put(1'b1, 1'b0);
    step();
    fill(0); pix[2] = 255; pix[5] = 128; pix[8] = 1; put(1'b1, 1'b0);
    step(); idle();
    step(); step();
`ifdef WINFILT_THRESH_EN
    chk("thr_127", 64'(bus.out), 64'h100);
    step();
    chk("thr_128", 64'(bus.out), 64'h1FF);
`else
    chk("thr_127", 64'(bus.out), 64'h17F);
    step();
    chk("thr_128", 64'(bus.out), 64'h180);
`endif

    // Mode switch to pass-through while six windows stream back to back
    bus.mode_in = 2'd0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k >= 5) chk("switch", 64'(bus.out), 64'(exp_sw(k - 4)));
      fill(10 * k); pix[0] = 0; pix[3] = 0; pix[6] = 0; pix[4] = 8'(200 + k);
      put(1'b1, 1'b0);
      bus.mode_load = (k == 3);
    end
    for (int j = 3; j <= 6; j++) begin
      step();
      if (j == 3) idle();
      chk("switch", 64'(bus.out), 64'(exp_sw(j)));
    end

    // Refresh with three windows in flight
    for (int k = 1; k <= 3; k++) begin
      step();
      fill(50 + k); put(1'b1, 1'b0);
    end
    step();
    bus.refresh = 1'b1; idle();
    step();
    bus.refresh = 1'b0;
    chk("refr_cnt", 64'(bus.pix_cnt), 64'd0);
    chk("refr_mode", 64'(bus.mode_q), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("refr_out", 64'(bus.out), 64'd0);
    end

    // Load and refresh together: the load still takes effect
    bus.refresh = 1'b1; bus.mode_load = 1'b1; bus.mode_in = 2'd2;
    step();
    bus.refresh = 1'b0; bus.mode_load = 1'b0;
    chk("refr_load_mode", 64'(bus.mode_q), 64'd2);

    // Invalid centre with every other flag set
    fill(255); put(1'b0, 1'b1);
    step(); idle();
    step(); step(); step();
    chk("inval_out", 64'(bus.out), 64'd0);
    chk("inval_cnt", 64'(bus.pix_cnt), 64'd0);

    // Mixed traffic against the model
    for (int k = 0; k < 80; k++) begin
      step();
      rand_win();
      bus.mode_load = ($urandom_range(0, 4) == 0);
      bus.mode_in = 2'($urandom);
      bus.refresh = ($urandom_range(0, 16) == 0);
    end
    step();
    bus.mode_load = 1'b0; bus.refresh = 1'b0; idle();
    for (int k = 0; k < 6; k++) step();

    // Reset overrides a simultaneous mode load
    rst = 1'b1; bus.mode_load = 1'b1; bus.mode_in = 2'd2;
    step();
    rst = 1'b0; bus.mode_load = 1'b0;
    chk("rst_load_mode", 64'(bus.mode_q), 64'd1);
    chk("rst2_cnt", 64'(bus.pix_cnt), 64'd0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
